tp84_hiscore_ctrl: RTL and testbench

Initiator side of the Time Pilot '84 high-score port (`hs_address`/`hs_data_in`/`hs_data_out`/`hs_write`/`hs_access`). It holds a byte buffer of the score table, loaded from the SD card through the ioctl download path. On request it pauses the game and writes the buffer into game RAM (restore), or reads game RAM back into the buffer (save) for upload. It sits in the core top beside the game instance and drives that instance's `pause` input.

---
 rtl/tp84_hs_pkg.sv | 27 ++
 rtl/tp84_hs_buffer.sv | 28 ++
 rtl/tp84_hiscore_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_tp84_hiscore_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp84_hs_pkg.sv
// Shared types and default constants for the Time Pilot '84 high-score controller.
package tp84_hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PAUSE = 3'd1,
        ST_CHECK = 3'd2,
        ST_WAIT  = 3'd3,
        ST_XFER  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } hs_state_t;

    typedef enum logic {
        MODE_RESTORE = 1'b0,
        MODE_SAVE    = 1'b1
    } hs_mode_t;

    localparam logic [15:0] HS_BASE_DEF   = 16'h5700;
    localparam int          HS_LEN_DEF    = 64;
    localparam int          PAUSE_CYC_DEF = 16;
    localparam int          ACC_CYC_DEF   = 4;
    localparam logic [7:0]  START_VAL_DEF = 8'h00;
    localparam logic [7:0]  END_VAL_DEF   = 8'h00;
    localparam int          POLL_CYC_DEF  = 4096;

endpackage

// File: rtl/tp84_hs_buffer.sv
// 256x8 score buffer: port A read/write (async read), port B registered read for upload.
module tp84_hs_buffer (
    input  logic       clk,
    input  logic [7:0] a_addr,
    input  logic       a_we,
    input  logic [7:0] a_wdata,
    output logic [7:0] a_rdata,
    input  logic [7:0] b_addr,
    output logic [7:0] b_rdata
);

    logic [7:0] mem_r [256];

    // Port A write.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_r[a_addr] <= a_wdata;
        end
    end

    assign a_rdata = mem_r[a_addr];

    // Port B registered upload read.
    always_ff @(posedge clk) begin
        b_rdata <= mem_r[b_addr];
    end

endmodule

// File: rtl/tp84_hiscore_ctrl.sv
// High-score buffer and restore/save engine driving the game's pause and hs_* port.
// Define TP84_HS_CHECK_EN to compare the table's first/last game bytes before restoring.
module tp84_hiscore_ctrl
    import tp84_hs_pkg::*;
#(
    parameter logic [15:0] HS_BASE   = HS_BASE_DEF,
    parameter int          HS_LEN    = HS_LEN_DEF,
    parameter int          PAUSE_CYC = PAUSE_CYC_DEF,
    parameter int          ACC_CYC   = ACC_CYC_DEF,
    parameter logic [7:0]  START_VAL = START_VAL_DEF,
    parameter logic [7:0]  END_VAL   = END_VAL_DEF,
    parameter int          POLL_CYC  = POLL_CYC_DEF
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        restore_req,
    input  logic        save_req,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        hs_dl,
    input  logic [7:0]  up_addr,
    output logic [7:0]  up_data,
    output logic        pause_cpu,
    output logic [15:0] hs_address,
    output logic [7:0]  hs_data_in,
    input  logic [7:0]  hs_data_out,
    output logic        hs_write,
    output logic        hs_access,
    output logic        busy,
    output logic        done,
    output logic        buf_valid
);

`ifdef TP84_HS_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    hs_state_t   state_r, state_nxt_s;
    hs_mode_t    mode_r, mode_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [7:0]  idx_r, idx_nxt_s;
    logic        chk_sel_r, chk_sel_nxt_s;
    logic        chk_ok_r, chk_ok_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        pause_r, pause_nxt_s;
    logic        access_r, access_nxt_s;
    logic        write_r, write_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic [15:0] addr_r, addr_nxt_s;
    logic [7:0]  din_r, din_nxt_s;

    logic        dl_wr_s;
    logic [7:0]  a_addr_s;
    logic        a_we_s;
    logic [7:0]  a_wdata_s;
    logic [7:0]  a_rdata_s;

    assign dl_wr_s = ioctl_wr && hs_dl && (ioctl_addr < 25'(HS_LEN)) && (state_r == ST_IDLE);

    // Next-state decode for the transfer engine.
    always_comb begin
        state_nxt_s   = state_r;
        mode_nxt_s    = mode_r;
        cnt_nxt_s     = cnt_r;
        idx_nxt_s     = idx_r;
        chk_sel_nxt_s = chk_sel_r;
        chk_ok_nxt_s  = chk_ok_r;
        valid_nxt_s   = valid_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 16'd0;
                idx_nxt_s = 8'd0;
                // restore has priority; an invalid buffer swallows the request
                if (restore_req) begin
                    if (valid_r) begin
                        state_nxt_s = ST_PAUSE;
                        mode_nxt_s  = MODE_RESTORE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (save_req) begin
                    state_nxt_s = ST_PAUSE;
                    mode_nxt_s  = MODE_SAVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                if (dl_wr_s && (ioctl_addr[7:0] == 8'(HS_LEN - 1))) begin
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            ST_PAUSE: begin
                if (cnt_r == 16'(PAUSE_CYC - 1)) begin
                    cnt_nxt_s     = 16'd0;
                    idx_nxt_s     = 8'd0;
                    chk_sel_nxt_s = 1'b0;
                    chk_ok_nxt_s  = 1'b0;
                    if (CHK_EN && (mode_r == MODE_RESTORE)) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_XFER;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_CHECK: begin
                // cnt 0..ACC_CYC-1 is the read window, cnt == ACC_CYC the gap
                if (cnt_r == 16'(ACC_CYC - 1)) begin
                    if (chk_sel_r) begin
                        chk_ok_nxt_s = chk_ok_r && (hs_data_out == END_VAL);
                    end else begin
                        chk_ok_nxt_s = (hs_data_out == START_VAL);
                    end
                end else begin
                    chk_ok_nxt_s = chk_ok_r;
                end
                if (cnt_r == 16'(ACC_CYC)) begin
                    cnt_nxt_s = 16'd0;
                    if (!chk_sel_r) begin
                        chk_sel_nxt_s = 1'b1;
                    end else if (chk_ok_r) begin
                        state_nxt_s = ST_XFER;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 16'(POLL_CYC - 1)) begin
                    cnt_nxt_s   = 16'd0;
                    state_nxt_s = ST_PAUSE;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_XFER: begin
                if (cnt_r == 16'(ACC_CYC - 1)) begin
                    cnt_nxt_s   = 16'd0;
                    state_nxt_s = ST_GAP;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            ST_GAP: begin
                if (idx_r == 8'(HS_LEN - 1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    idx_nxt_s   = idx_r + 8'd1;
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                if (mode_r == MODE_SAVE) begin
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every port is a flop.
    always_comb begin
        pause_nxt_s  = (state_nxt_s == ST_PAUSE) || (state_nxt_s == ST_CHECK) ||
                       (state_nxt_s == ST_XFER)  || (state_nxt_s == ST_GAP);
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        done_nxt_s   = (state_nxt_s == ST_DONE);
        access_nxt_s = (state_nxt_s == ST_XFER) ||
                       ((state_nxt_s == ST_CHECK) && (cnt_nxt_s < 16'(ACC_CYC)));
        write_nxt_s  = (state_nxt_s == ST_XFER) && (mode_nxt_s == MODE_RESTORE);
        addr_nxt_s   = addr_r;
        din_nxt_s    = din_r;
        if (state_nxt_s == ST_XFER) begin
            addr_nxt_s = HS_BASE + {8'h00, idx_nxt_s};
        end else if (state_nxt_s == ST_CHECK) begin
            addr_nxt_s = chk_sel_nxt_s ? (HS_BASE + 16'(HS_LEN - 1)) : HS_BASE;
        end else begin
            addr_nxt_s = addr_r;
        end
        if (write_nxt_s) begin
            din_nxt_s = a_rdata_s;
        end else begin
            din_nxt_s = din_r;
        end
    end

    // Buffer port A: download path in IDLE, engine otherwise.
    always_comb begin
        a_addr_s  = ioctl_addr[7:0];
        a_we_s    = 1'b0;
        a_wdata_s = ioctl_data;
        if (state_r == ST_IDLE) begin
            a_addr_s  = ioctl_addr[7:0];
            a_we_s    = dl_wr_s;
            a_wdata_s = ioctl_data;
        end else begin
            a_addr_s  = idx_nxt_s;
            a_we_s    = (state_r == ST_XFER) && (mode_r == MODE_SAVE) &&
                        (cnt_r == 16'(ACC_CYC - 1));
            a_wdata_s = hs_data_out;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            mode_r    <= MODE_RESTORE;
            cnt_r     <= 16'd0;
            idx_r     <= 8'd0;
            chk_sel_r <= 1'b0;
            chk_ok_r  <= 1'b0;
            valid_r   <= 1'b0;
            pause_r   <= 1'b0;
            access_r  <= 1'b0;
            write_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            addr_r    <= 16'h0000;
            din_r     <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            mode_r    <= mode_nxt_s;
            cnt_r     <= cnt_nxt_s;
            idx_r     <= idx_nxt_s;
            chk_sel_r <= chk_sel_nxt_s;
            chk_ok_r  <= chk_ok_nxt_s;
            valid_r   <= valid_nxt_s;
            pause_r   <= pause_nxt_s;
            access_r  <= access_nxt_s;
            write_r   <= write_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            addr_r    <= addr_nxt_s;
            din_r     <= din_nxt_s;
        end
    end

    tp84_hs_buffer u_buffer (
        .clk     (clk_49m),
        .a_addr  (a_addr_s),
        .a_we    (a_we_s),
        .a_wdata (a_wdata_s),
        .a_rdata (a_rdata_s),
        .b_addr  (up_addr),
        .b_rdata (up_data)
    );

    assign pause_cpu  = pause_r;
    assign hs_access  = access_r;
    assign hs_write   = write_r;
    assign hs_address = addr_r;
    assign hs_data_in = din_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign buf_valid  = valid_r;

endmodule

// File: tb/tb_tp84_hiscore_ctrl.sv
// Self-checking bench for tp84_hiscore_ctrl: game RAM model, window monitor and buffer model.
module tb_tp84_hiscore_ctrl;

    localparam int          LEN  = 64;
    localparam int          PCYC = 16;
    localparam int          ACC  = 4;
    localparam int          POLL = 4096;
    localparam logic [15:0] BASE = 16'h5700;
    localparam int          LAT  = 1 + PCYC + LEN * (ACC + 1) + 1;

    logic        clk_49m = 1'b0;
    logic        reset, restore_req, save_req, ioctl_wr, hs_dl;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data, up_addr, up_data, hs_data_in, hs_data_out;
    logic        pause_cpu, hs_write, hs_access, busy, done, buf_valid;
    logic [15:0] hs_address;

    logic [7:0]  gram [0:65535];
    logic [7:0]  mbuf [0:255];
    bit          mvalid, mbusy;
    int          checks = 0, failures = 0, req_cyc = 0;

    // monitor state, written only by the monitor process
    int          cyc = 0, win_cnt = 0, len_err = 0, stable_err = 0, done_cnt = 0;
    int          pause_hi = 0, low_len = 0, last_low = 0, low_runs = 0, acc_len = 0;
    logic        prev_acc = 1'b0, prev_wr = 1'b0, prev_pause = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [7:0]  prev_din = 8'h00;
    logic [15:0] win_addr [0:1023];
    logic [7:0]  win_data [0:1023];
    logic        win_wr   [0:1023];

    always #5 clk_49m = ~clk_49m;

    assign hs_data_out = gram[hs_address];

    tp84_hiscore_ctrl dut (
        .clk_49m(clk_49m), .reset(reset), .restore_req(restore_req), .save_req(save_req),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .hs_dl(hs_dl),
        .up_addr(up_addr), .up_data(up_data), .pause_cpu(pause_cpu), .hs_address(hs_address),
        .hs_data_in(hs_data_in), .hs_data_out(hs_data_out), .hs_write(hs_write),
        .hs_access(hs_access), .busy(busy), .done(done), .buf_valid(buf_valid)
    );

    always @(posedge clk_49m) cyc <= cyc + 1;

    always @(negedge clk_49m) begin
        prev_acc   <= hs_access;
        prev_addr  <= hs_address;
        prev_din   <= hs_data_in;
        prev_wr    <= hs_write;
        prev_pause <= pause_cpu;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (pause_cpu === 1'b1) pause_hi <= pause_hi + 1;
        if (pause_cpu !== 1'b1) low_len <= low_len + 1;
        else low_len <= 0;
        if (pause_cpu === 1'b1 && prev_pause !== 1'b1) begin
            last_low <= low_len;
            low_runs <= low_runs + 1;
        end
        if (hs_access === 1'b1 && prev_acc !== 1'b1) begin
            win_addr[win_cnt % 1024] <= hs_address;
            win_data[win_cnt % 1024] <= hs_data_in;
            win_wr[win_cnt % 1024]   <= hs_write;
            win_cnt <= win_cnt + 1;
            acc_len <= 1;
        end else if (hs_access === 1'b1) begin
            acc_len <= acc_len + 1;
            if (hs_address !== prev_addr || hs_data_in !== prev_din || hs_write !== prev_wr)
                stable_err <= stable_err + 1;
        end else if (prev_acc === 1'b1 && acc_len != ACC) begin
            len_err <= len_err + 1;
        end
    end

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input logic sel);
        @(negedge clk_49m);
        ioctl_wr = 1'b1; hs_dl = sel; ioctl_addr = a; ioctl_data = d;
        if (sel && a < 25'(LEN) && !mbusy) begin
            mbuf[a[7:0]] = d;
            if (a == 25'(LEN - 1)) mvalid = 1'b1;
        end
        @(negedge clk_49m);
        ioctl_wr = 1'b0; hs_dl = 1'b0;
    endtask

    task automatic pulse(input logic r, input logic s);
        @(negedge clk_49m);
        restore_req = r; save_req = s; req_cyc = cyc;
        @(negedge clk_49m);
        restore_req = 1'b0; save_req = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int lat, output bit seen);
        seen = 1'b0;
        while (!seen && (cyc - req_cyc) < bound) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk_49m);
        end
        lat = cyc - req_cyc + 1;
    endtask

    function automatic int count_bad(input int w0, input bit wr_exp, input bit chk_data);
        int bad = 0;
        for (int i = 0; i < LEN; i++) begin
            int k = (w0 + i) % 1024;
            if (win_addr[k] !== 16'(int'(BASE) + i) || win_wr[k] !== wr_exp ||
                (chk_data && win_data[k] !== mbuf[i]))
                bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_49m);
        checks++; if (pause_cpu !== 1'b0) begin failures++; $display("FAIL reset_pause got=%b exp=0", pause_cpu); end
        checks++; if (hs_access !== 1'b0) begin failures++; $display("FAIL reset_access got=%b exp=0", hs_access); end
        checks++; if (hs_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b exp=0", hs_write); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (buf_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", buf_valid); end
        checks++; if (hs_address !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", hs_address); end
        checks++; if (hs_data_in !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", hs_data_in); end
        reset = 1'b0; mvalid = 1'b0; mbusy = 1'b0;
        @(negedge clk_49m);
    endtask

`ifndef TP84_HS_CHECK_EN
    task automatic test_restore();
        int w0, d0, l0, s0, lat, bad;
        bit seen;
        for (int i = 0; i < LEN; i++) dl_byte(25'(i), 8'(8'hA0 + i), 1'b1);
        @(negedge clk_49m);
        checks++; if (buf_valid !== 1'b1) begin failures++; $display("FAIL dl_valid got=%b exp=1", buf_valid); end
        w0 = win_cnt; d0 = done_cnt; l0 = len_err; s0 = stable_err;
        pulse(1'b1, 1'b0); mbusy = 1'b1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restore_busy got=%b exp=1", busy); end
        wait_done(LAT + 100, lat, seen); mbusy = 1'b0;
        checks++; if (!seen || lat != LAT) begin failures++; $display("FAIL restore_latency got=%0d seen=%0d exp=%0d", lat, seen, LAT); end
        @(negedge clk_49m);
        checks++; if (win_cnt - w0 != LEN) begin failures++; $display("FAIL restore_windows got=%0d exp=%0d", win_cnt - w0, LEN); end
        bad = count_bad(w0, 1'b1, 1'b1);
        checks++; if (bad != 0) begin failures++; $display("FAIL restore_window_content bad=%0d exp=0", bad); end
        checks++; if (len_err != l0 || stable_err != s0) begin failures++; $display("FAIL restore_window_shape len_err=%0d stable_err=%0d exp=0", len_err - l0, stable_err - s0); end
        checks++; if (busy !== 1'b0 || pause_cpu !== 1'b0 || done_cnt - d0 != 1) begin failures++; $display("FAIL restore_end busy=%b pause=%b dones=%0d exp=0/0/1", busy, pause_cpu, done_cnt - d0); end
        for (int i = 0; i < LEN; i++) gram[int'(BASE) + i] = mbuf[i];
    endtask

    task automatic test_save();
        int w0, lat, bad;
        bit seen;
        for (int i = 0; i < LEN; i++) gram[int'(BASE) + i] = 8'(i);
        w0 = win_cnt;
        pulse(1'b0, 1'b1); mbusy = 1'b1;
        wait_done(LAT + 100, lat, seen); mbusy = 1'b0;
        checks++; if (!seen || lat != LAT) begin failures++; $display("FAIL save_latency got=%0d seen=%0d exp=%0d", lat, seen, LAT); end
        for (int i = 0; i < LEN; i++) mbuf[i] = gram[int'(BASE) + i];
        mvalid = 1'b1;
        @(negedge clk_49m);
        bad = count_bad(w0, 1'b0, 1'b0);
        checks++; if (win_cnt - w0 != LEN || bad != 0) begin failures++; $display("FAIL save_windows got=%0d bad=%0d exp=%0d", win_cnt - w0, bad, LEN); end
        checks++; if (buf_valid !== 1'b1) begin failures++; $display("FAIL save_valid got=%b exp=1", buf_valid); end
        up_addr = 8'd5;
        @(negedge clk_49m);
        checks++; if (up_data !== 8'h05) begin failures++; $display("FAIL upload_5 got=%h exp=05", up_data); end
    endtask

    task automatic test_both_requests();
        int w0, d0, lat, bad;
        bit seen;
        for (int i = 0; i < LEN; i++) dl_byte(25'(i), 8'($urandom), 1'b1);
        w0 = win_cnt; d0 = done_cnt;
        pulse(1'b1, 1'b1); mbusy = 1'b1;
        while ((cyc - req_cyc + 1) < 50) @(negedge clk_49m);
        restore_req = 1'b1;
        @(negedge clk_49m);
        restore_req = 1'b0;
        wait_done(LAT + 100, lat, seen); mbusy = 1'b0;
        checks++; if (!seen || lat != LAT) begin failures++; $display("FAIL both_latency got=%0d seen=%0d exp=%0d", lat, seen, LAT); end
        repeat (400) @(negedge clk_49m);
        bad = count_bad(w0, 1'b1, 1'b1);
        checks++; if (win_cnt - w0 != LEN || bad != 0 || done_cnt - d0 != 1) begin failures++; $display("FAIL both_windows got=%0d bad=%0d dones=%0d exp=%0d/0/1", win_cnt - w0, bad, done_cnt - d0, LEN); end
        for (int i = 0; i < LEN; i++) gram[int'(BASE) + i] = mbuf[i];
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = win_cnt;
        pulse(1'b1, 1'b0); mbusy = 1'b1;
        while (win_cnt - w0 < 10 && (cyc - req_cyc) < LAT) @(negedge clk_49m);
        checks++; if (hs_access !== 1'b1) begin failures++; $display("FAIL reset_mid_in_window got=%b exp=1", hs_access); end
        reset = 1'b1;
        @(negedge clk_49m);
        checks++; if (pause_cpu !== 1'b0 || hs_access !== 1'b0 || busy !== 1'b0 || buf_valid !== 1'b0) begin failures++; $display("FAIL reset_mid pause=%b acc=%b busy=%b valid=%b exp=0000", pause_cpu, hs_access, busy, buf_valid); end
        reset = 1'b0; mvalid = 1'b0; mbusy = 1'b0;
        @(negedge clk_49m);
    endtask

    task automatic test_restore_invalid();
        int w0, d0, p0;
        w0 = win_cnt; d0 = done_cnt; p0 = pause_hi;
        pulse(1'b1, 1'b0);
        repeat (400) @(negedge clk_49m);
        checks++; if (pause_hi != p0 || win_cnt != w0 || done_cnt != d0) begin failures++; $display("FAIL invalid_restore pause=%0d win=%0d done=%0d exp=0/0/0", pause_hi - p0, win_cnt - w0, done_cnt - d0); end
    endtask

    task automatic test_random();
        int w0, lat, bad;
        bit seen, rst_op;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < LEN; i++) gram[int'(BASE) + i] = 8'($urandom);
            for (int i = 0; i < LEN; i++) begin
                dl_byte(25'(i), 8'($urandom), 1'b1);
                if ($urandom_range(0, 3) == 0) dl_byte(25'(LEN + $urandom_range(0, 100)), 8'($urandom), 1'b1);
                if ($urandom_range(0, 3) == 0) dl_byte(25'h100000 | 25'($urandom_range(0, LEN - 1)), 8'($urandom), 1'b1);
                if ($urandom_range(0, 3) == 0) dl_byte(25'($urandom_range(0, LEN - 1)), 8'($urandom), 1'b0);
            end
            rst_op = 1'($urandom_range(0, 1));
            w0 = win_cnt;
            pulse(rst_op, !rst_op); mbusy = 1'b1;
            dl_byte(25'd0, ~mbuf[0], 1'b1);
            @(negedge clk_49m); save_req = 1'b1;
            @(negedge clk_49m); save_req = 1'b0;
            wait_done(LAT + 100, lat, seen); mbusy = 1'b0;
            checks++; if (!seen || lat != LAT) begin failures++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, LAT); end
            if (!rst_op) begin
                for (int i = 0; i < LEN; i++) mbuf[i] = gram[int'(BASE) + i];
                mvalid = 1'b1;
            end
            @(negedge clk_49m);
            bad = count_bad(w0, rst_op, rst_op);
            checks++; if (win_cnt - w0 != LEN || bad != 0) begin failures++; $display("FAIL rand_windows it=%0d got=%0d bad=%0d exp=%0d", it, win_cnt - w0, bad, LEN); end
            if (rst_op) for (int i = 0; i < LEN; i++) gram[int'(BASE) + i] = mbuf[i];
            bad = 0;
            for (int i = 0; i < LEN; i++) begin
                up_addr = 8'(i);
                @(negedge clk_49m);
                if (up_data !== mbuf[i]) bad++;
            end
            checks++; if (bad != 0 || buf_valid !== mvalid) begin failures++; $display("FAIL rand_upload it=%0d bad=%0d valid=%b exp=0/%b", it, bad, buf_valid, mvalid); end
        end
    endtask
`endif

`ifdef TP84_HS_CHECK_EN
    task automatic test_check();
        int w0, d0, r0, lat, wr;
        bit seen;
        for (int i = 0; i < LEN; i++) dl_byte(25'(i), 8'(8'hA0 + i), 1'b1);
        gram[int'(BASE)] = 8'hFF; gram[int'(BASE) + LEN - 1] = 8'h00;
        w0 = win_cnt; d0 = done_cnt; r0 = low_runs;
        pulse(1'b1, 1'b0); mbusy = 1'b1;
        repeat (3 * POLL + 200) @(negedge clk_49m);
        wr = 0;
        for (int k = w0; k < win_cnt; k++) if (win_wr[k % 1024] === 1'b1) wr++;
        checks++; if (wr != 0 || done_cnt != d0) begin failures++; $display("FAIL check_blocked writes=%0d dones=%0d exp=0/0", wr, done_cnt - d0); end
        checks++; if (low_runs - r0 < 2 || last_low != POLL) begin failures++; $display("FAIL check_poll runs=%0d low=%0d exp>=2/%0d", low_runs - r0, last_low, POLL); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL check_busy got=%b exp=1", busy); end
        gram[int'(BASE)] = 8'h00;
        wait_done((cyc - req_cyc) + 2 * POLL + 1000, lat, seen); mbusy = 1'b0;
        checks++; if (!seen) begin failures++; $display("FAIL check_done got=0 exp=1 after %0d cycles", lat); end
        @(negedge clk_49m);
        wr = 0;
        for (int k = w0; k < win_cnt; k++) if (win_wr[k % 1024] === 1'b1) wr++;
        checks++; if (wr != LEN) begin failures++; $display("FAIL check_writes got=%0d exp=%0d", wr, LEN); end
    endtask
`endif

    initial begin
        reset = 1'b1; restore_req = 1'b0; save_req = 1'b0; ioctl_wr = 1'b0; hs_dl = 1'b0;
        ioctl_addr = 25'd0; ioctl_data = 8'h00; up_addr = 8'h00;
        mvalid = 1'b0; mbusy = 1'b0;
        for (int i = 0; i < 65536; i++) gram[i] = 8'h00;
        for (int i = 0; i < 256; i++) mbuf[i] = 8'h00;
        test_reset();
`ifdef TP84_HS_CHECK_EN
        test_check();
`else
        test_restore();
        test_save();
        test_both_requests();
        test_reset_mid();
        test_restore_invalid();
        test_random();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
